// File: rtl/bnn_neuron_feeder.sv
`default_nettype none
// ============================================================================
// Module   : bnn_neuron_feeder
// Brief    : Transmit-side driver for a BNN neuron processor. Buffers one
//            binarized input vector, streams x/w chunk pairs per neuron from
//            an external weight RAM, presents the neuron threshold, and
//            collects the per-neuron result bits into a result vector.
// Revision : 1.0  initial release
// ============================================================================
module bnn_neuron_feeder #(
    parameter int PARALLEL_INPUTS = 8,
    parameter int NUM_INPUTS      = 64,
    parameter int NUM_NEURONS     = 4,
    parameter int THRESH_W        = 32,
    parameter int W_ADDR_W        = ((NUM_NEURONS * (NUM_INPUTS / PARALLEL_INPUTS)) > 1)
                                    ? $clog2(NUM_NEURONS * (NUM_INPUTS / PARALLEL_INPUTS)) : 1,
    parameter int T_ADDR_W        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PARALLEL_INPUTS-1:0] in_data,
    output logic [W_ADDR_W-1:0]        w_addr,
    input  logic [PARALLEL_INPUTS-1:0] w_rdata,
    output logic [T_ADDR_W-1:0]        t_addr,
    input  logic [THRESH_W-1:0]        t_rdata,
    output logic [PARALLEL_INPUTS-1:0] x,
    output logic [PARALLEL_INPUTS-1:0] w,
    output logic [THRESH_W-1:0]        threshold,
    output logic                       valid_out,
    output logic                       eof,
    input  logic                       nr_valid,
    input  logic                       nr_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [NUM_NEURONS-1:0]     res_data
);

    localparam int BEATS  = NUM_INPUTS / PARALLEL_INPUTS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NEUR_W = T_ADDR_W;

    localparam logic [BEAT_W-1:0] C_LAST_BEAT   = BEAT_W'(BEATS - 1);
    localparam logic [NEUR_W-1:0] C_LAST_NEURON = NEUR_W'(NUM_NEURONS - 1);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    logic [1:0]                 state_q,    state_d;
    logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [NEUR_W-1:0]          n_q,        n_d;
    logic [BEAT_W-1:0]          c_q,        c_d;
    logic [T_ADDR_W-1:0]        t_addr_q,   t_addr_d;
    logic [NUM_NEURONS-1:0]     res_q,      res_d;
    logic                       valid_q;
    logic                       eof_q;
    logic [PARALLEL_INPUTS-1:0] x_q;
    logic [PARALLEL_INPUTS-1:0] buf_q [BEATS];

    logic                       in_beat;
    logic                       streaming;
    logic [W_ADDR_W-1:0]        addr_calc;

    assign in_beat   = in_valid && (state_q == S_LOAD);
    assign streaming = (state_q == S_STREAM);
    assign addr_calc = W_ADDR_W'(n_q) * W_ADDR_W'(BEATS) + W_ADDR_W'(c_q);

    // Next-state and counter logic for the LOAD/STREAM/WAIT/RESULT sequence
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        n_d        = n_q;
        c_d        = c_q;
        t_addr_d   = t_addr_q;
        res_d      = res_q;
        case (state_q)
            S_LOAD: begin
                if (in_beat) begin
                    if (beat_cnt_q == C_LAST_BEAT) begin
                        beat_cnt_d = '0;
                        n_d        = '0;
                        c_d        = '0;
                        t_addr_d   = '0;
                        state_d    = S_STREAM;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (c_q == C_LAST_BEAT) begin
                    c_d     = '0;
                    state_d = S_WAIT;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (nr_valid) begin
                    res_d[n_q] = nr_out;
                    if (n_q == C_LAST_NEURON) begin
                        state_d = S_RESULT;
                    end else begin
                        n_d      = n_q + 1'b1;
                        c_d      = '0;
                        t_addr_d = n_q + 1'b1;
                        state_d  = S_STREAM;
                    end
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Control state, counters and result vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            beat_cnt_q <= '0;
            n_q        <= '0;
            c_q        <= '0;
            t_addr_q   <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            n_q        <= n_d;
            c_q        <= c_d;
            t_addr_q   <= t_addr_d;
            res_q      <= res_d;
        end
    end

    // Output pipeline stage aligned with the 1-cycle weight RAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            x_q     <= '0;
        end else begin
            valid_q <= streaming;
            eof_q   <= streaming && (c_q == C_LAST_BEAT);
            x_q     <= streaming ? buf_q[c_q] : '0;
        end
    end

    // Input vector buffer; stale contents are harmless since loads restart at beat 0
    always_ff @(posedge clk) begin
        if (in_beat) begin
            buf_q[beat_cnt_q] <= in_data;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign w_addr    = streaming ? addr_calc : '0;
    assign t_addr    = t_addr_q;
    assign threshold = t_rdata;
    assign x         = x_q;
    assign w         = valid_q ? w_rdata : '0;
    assign valid_out = valid_q;
    assign eof       = eof_q;
    assign res_valid = (state_q == S_RESULT);
    assign res_data  = res_q;

    // A result from the neuron processor is only meaningful while waiting for one
    a_nr_valid_in_wait: assert property (
        @(posedge clk) disable iff (!rst_n) nr_valid |-> (state_q == S_WAIT)
    ) else $warning("protocol error: nr_valid outside WAIT ignored");

endmodule
`default_nettype wire

// File: doc/bnn_neuron_feeder.md
Name: bnn_neuron_feeder

Overview:
- Transmit-side driver for the BNN neuron processor.
- Accepts one binarized input vector as PARALLEL_INPUTS-bit beats and buffers it.
- For each neuron in turn, reads weight chunks from an external weight RAM and streams x/w chunk pairs with valid and eof. Presents that neuron's threshold.
- Collects each neuron's 1-bit result into a result vector, delivered over a valid/ready handshake.

Parameters:
PARALLEL_INPUTS, 8, bits per chunk (x, w, input beat width)
NUM_INPUTS, 64, input vector length; must be a multiple of PARALLEL_INPUTS; BEATS = NUM_INPUTS/PARALLEL_INPUTS
NUM_NEURONS, 4, neurons evaluated per input vector
THRESH_W, 32, threshold width
W_ADDR_W, $clog2(NUM_NEURONS*BEATS), weight RAM address width (min 1)
T_ADDR_W, $clog2(NUM_NEURONS), threshold RAM address width (min 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  feeder can accept an input beat
in_data  in  PARALLEL_INPUTS  input beat; beat 0 is loaded first
w_addr  out  W_ADDR_W  weight RAM read address
w_rdata  in  PARALLEL_INPUTS  weight RAM data; 1-cycle read latency
t_addr  out  T_ADDR_W  threshold RAM address
t_rdata  in  THRESH_W  threshold RAM data; 1-cycle read latency
x  out  PARALLEL_INPUTS  input chunk to neuron processor
w  out  PARALLEL_INPUTS  weight chunk to neuron processor
threshold  out  THRESH_W  threshold for current neuron (= t_rdata)
valid_out  out  1  x/w chunk valid
eof  out  1  last chunk of current neuron; only high with valid_out
nr_valid  in  1  neuron processor result valid
nr_out  in  1  neuron processor result bit
res_valid  out  1  result vector valid
res_ready  in  1  downstream accepts result vector
res_data  out  NUM_NEURONS  bit n = result of neuron n

Behaviour:
- Reset (async assert, sync release): state LOAD, all counters 0. in_ready=1. All other outputs 0: valid_out, eof, res_valid, res_data, x, w, w_addr, t_addr.
- FSM states: LOAD, STREAM, WAIT, RESULT.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready beat writes buffer[beat_cnt] and increments beat_cnt.
  - On the beat where beat_cnt==BEATS-1: beat_cnt←0, neuron n←0, chunk c←0, go STREAM.
- STREAM:
  - in_ready=0.
  - Each cycle: issue w_addr = n*BEATS + c, then c increments.
  - One cycle later: valid_out=1, x=buffer[c_d], w=w_rdata, eof=(c_d==BEATS-1), where c_d is c delayed 1 cycle.
  - After issuing c==BEATS-1, go WAIT.
  - Result: exactly BEATS consecutive valid_out cycles per neuron, with no gaps.
- t_addr:
  - Set to n on entry to STREAM and held through WAIT.
  - threshold is therefore stable from the first chunk until the result returns.
- WAIT:
  - Trailing pipelined chunk completes first.
  - On nr_valid: res_data[n]←nr_out.
  - If n==NUM_NEURONS-1, go RESULT; else n++, c←0, go STREAM.
- RESULT:
  - res_valid=1, res_data held stable until res_ready.
  - On res_valid&res_ready: res_valid←0, go LOAD.
  - res_data keeps its value until overwritten.
- nr_valid outside WAIT is ignored. Simulation assertion flags it as a protocol error.
- in_valid while in_ready=0 is ignored; the beat is not consumed.
- BEATS==1: every valid_out carries eof=1.
- NUM_NEURONS==1: WAIT goes directly to RESULT.
- Reset mid-operation: outputs drop immediately; partial buffer and results discarded. Next load restarts w_addr at 0.
- Throughput per vector: BEATS (load) + NUM_NEURONS*(BEATS+1+neuron latency) + 1 (result) cycles.

Test Plan:
Config for tests 1–5: P=8, NUM_INPUTS=16 (BEATS=2), NUM_NEURONS=2. Weight RAM {0:FF, 1:00, 2:5A, 3:C3}; threshold RAM {0:9, 1:4}.
1. Reset: hold rst_n=0 -> all outputs 0. After release -> in_ready=1, valid_out=0.
2. Load beats A5, 3C:
   - w_addr sequence 0,1 then 2,3.
   - valid_out chunks (x,w,eof): (A5,FF,0), (3C,00,1), threshold=9; then (A5,5A,0), (3C,C3,1), threshold=4.
   - in_ready=0 after second beat.
3. Neuron model returns nr_out=1 then 0; res_ready=0 for 5 cycles -> res_valid=1 with res_data=2'b01 held stable. res_ready=1 -> res_valid=0 next cycle, in_ready=1.
4. Load beats with 3-cycle in_valid gaps; pulse nr_valid during STREAM -> identical chunk stream as test 2; spurious nr_valid does not alter res_data.
5. Assert rst_n=0 mid-STREAM after first chunk -> valid_out=0 immediately. Reload and rerun -> w_addr restarts at 0, correct result vector.
6. Config P=8, NUM_INPUTS=8, NUM_NEURONS=3, back-to-back vectors with res_ready=1 -> every valid_out has eof=1; res_valid for exactly 1 cycle per vector; 3 results per vector.
